// File: rtl/accum_requant_sat.sv
// accum_requant_sat
//   Streaming requantiser that sits directly after the 2W-wide MAC accumulator.
//   A signed accumulator word is scaled down by 2^FRAC, saturated to the signed
//   W-bit range and tagged with overflow/underflow flags. Two pipeline stages with
//   valid/ready on both sides; sticky saturating counters record how many clipped
//   samples were handed downstream.
//
// Build option:
//   ROUND_NEAREST_EN  defined   -> add 2^(FRAC-1) before the bound check (round half up)
//                     undefined -> plain truncation (floor)
//
// Parameters:
//   W      output sample width (input is 2*W)
//   FRAC   output fractional bits (shift amount applied to the accumulator word)
//   CNT_W  width of each saturation event counter
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst        synchronous active-high reset
//   in_data    signed accumulator word (2*W bits)
//   in_valid   in_data valid
//   in_ready   stage 1 accepts in_data this cycle
//   out_data   signed saturated sample (W bits)
//   out_ovf    out_data was clipped to the positive limit
//   out_unf    out_data was clipped to the negative limit
//   out_valid  out_data and flags valid
//   out_ready  consumer accepts the output this cycle
//   cnt_clear  synchronous clear of both counters (wins over increment)
//   ovf_count  overflow samples handed off, saturating
//   unf_count  underflow samples handed off, saturating
module accum_requant_sat #(
  parameter int unsigned W     = 16,
  parameter int unsigned FRAC  = 12,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*W-1:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic             out_ovf,
  output logic             out_unf,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] unf_count
);

  // One guard bit over the accumulator so the rounding offset can never wrap.
  localparam int unsigned XW     = 2 * W + 1;
  localparam int unsigned SatExp = W - 1 + FRAC;

  // Bounds in the unshifted domain: HI = 2^(W-1+FRAC) - 1, LO = -2^(W-1+FRAC).
  localparam logic signed [XW-1:0] Hi = (XW'(1) << SatExp) - XW'(1);
  localparam logic signed [XW-1:0] Lo = ~Hi;

  localparam logic [W-1:0] PosMax = {1'b0, {(W - 1){1'b1}}};
  localparam logic [W-1:0] NegMax = {1'b1, {(W - 1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: pre-scale, bound check, slice
  // ---------------------------------------------------------------------------
  logic signed [XW-1:0] w_ext;
  logic signed [XW-1:0] w_v;
  logic                 w_ovf;
  logic                 w_unf;
  logic [W-1:0]         w_slice;

  assign w_ext = {in_data[2*W-1], in_data};

`ifdef ROUND_NEAREST_EN
  localparam logic signed [XW-1:0] RndOfs = XW'(1) << (FRAC - 1);
  assign w_v = w_ext + RndOfs;
`else
  assign w_v = w_ext;
`endif

  assign w_ovf   = (w_v > Hi);
  assign w_unf   = (w_v < Lo);
  // Floor of v / 2^FRAC; only meaningful when neither flag is set.
  assign w_slice = w_v[W+FRAC-1:FRAC];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic         r_s1_valid;
  logic [W-1:0] r_s1_slice;
  logic         r_s1_ovf;
  logic         r_s1_unf;

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_out_ovf;
  logic         r_out_unf;

  logic         w_adv2;
  logic         w_in_ready;
  logic         w_in_hs;
  logic         w_out_hs;

  assign w_adv2     = !r_out_valid || out_ready;
  // Stage 1 can take new data if it is empty or is draining into stage 2.
  assign w_in_ready = !r_s1_valid || w_adv2;
  assign w_in_hs    = w_in_ready && in_valid;
  assign w_out_hs   = r_out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Stage 1 register: slice of v plus flags (the slice is all stage 2 needs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_slice <= '0;
      r_s1_ovf   <= 1'b0;
      r_s1_unf   <= 1'b0;
    end else begin
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_hs) begin
        r_s1_slice <= w_slice;
        r_s1_ovf   <= w_ovf;
        r_s1_unf   <= w_unf;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: saturation mux and output register
  // ---------------------------------------------------------------------------
  logic [W-1:0] w_sat;

  always_comb begin
    w_sat = r_s1_slice;
    if (r_s1_ovf) begin
      w_sat = PosMax;
    end else if (r_s1_unf) begin
      w_sat = NegMax;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_unf   <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      // Payload only moves with a real sample so a bubble leaves the last value in place.
      if (r_s1_valid) begin
        r_out_data <= w_sat;
        r_out_ovf  <= r_s1_ovf;
        r_out_unf  <= r_s1_unf;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturation event counters, counted at the output handshake
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_ovf_cnt;
  logic [CNT_W-1:0] r_unf_cnt;
  logic [CNT_W-1:0] w_ovf_cnt_nxt;
  logic [CNT_W-1:0] w_unf_cnt_nxt;

  always_comb begin
    w_ovf_cnt_nxt = r_ovf_cnt;
    w_unf_cnt_nxt = r_unf_cnt;
    if (cnt_clear) begin
      w_ovf_cnt_nxt = '0;
      w_unf_cnt_nxt = '0;
    end else if (w_out_hs) begin
      if (r_out_ovf && !(&r_ovf_cnt)) begin
        w_ovf_cnt_nxt = r_ovf_cnt + CNT_W'(1);
      end
      if (r_out_unf && !(&r_unf_cnt)) begin
        w_unf_cnt_nxt = r_unf_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      r_ovf_cnt <= w_ovf_cnt_nxt;
      r_unf_cnt <= w_unf_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;
  assign out_unf   = r_out_unf;
  assign out_valid = r_out_valid;
  assign ovf_count = r_ovf_cnt;
  assign unf_count = r_unf_cnt;

endmodule

// File: tb/tb_accum_requant_sat.sv
module tb_accum_requant_sat;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clear;

  logic        in_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_unf;
  logic        out_valid;
  logic [15:0] ovf_count;
  logic [15:0] unf_count;

  // Second instance with 2-bit counters to observe counter saturation.
  logic        s_in_ready;
  logic [15:0] s_out_data;
  logic        s_out_ovf;
  logic        s_out_unf;
  logic        s_out_valid;
  logic [1:0]  s_ovf_count;
  logic [1:0]  s_unf_count;

  int n_checks = 0;
  int n_pass   = 0;

  accum_requant_sat #(.W(16), .FRAC(12), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_clear (cnt_clear),
    .ovf_count (ovf_count),
    .unf_count (unf_count)
  );

  accum_requant_sat #(.W(16), .FRAC(12), .CNT_W(2)) u_dut_small (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .out_data  (s_out_data),
    .out_ovf   (s_out_ovf),
    .out_unf   (s_out_unf),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .cnt_clear (cnt_clear),
    .ovf_count (s_ovf_count),
    .unf_count (s_unf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single sample through an idle pipeline, including its output handshake.
  task automatic send_one(input logic [31:0] d);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    step();
    step();
    n_checks++;
    if ({out_valid, out_data, out_ovf, out_unf} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
      $display("FAIL reset_out got v=%b d=%h o=%b u=%b exp 0/0000/0/0",
               out_valid, out_data, out_ovf, out_unf);
    end else n_pass++;
    n_checks++;
    if ({ovf_count, unf_count} !== 32'h0) begin
      $display("FAIL reset_cnt got ovf=%0d unf=%0d exp 0/0", ovf_count, unf_count);
    end else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end else n_pass++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    logic [31:0] vin [2];
    logic [15:0] vout [2];
    vin  = '{32'h0100_0000, 32'hF800_0000};
    vout = '{16'h1000, 16'h8000};
    for (int i = 0; i < 2; i++) begin
      in_data   = vin[i];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL nominal_latency[%0d] got out_valid=%b after 1 cycle exp 0", i, out_valid);
      end else n_pass++;
      step();
      n_checks++;
      if ({out_valid, out_data, out_ovf, out_unf} !== {1'b1, vout[i], 1'b0, 1'b0}) begin
        $display("FAIL nominal[%0d] got v=%b d=%h o=%b u=%b exp 1/%h/0/0",
                 i, out_valid, out_data, out_ovf, out_unf, vout[i]);
      end else n_pass++;
      step();
    end
  endtask

  task automatic test_clip();
    logic [31:0] vin [3];
    logic [15:0] vout [3];
    logic [1:0]  vfl [3];  // {ovf, unf}
    vin  = '{32'h0800_0000, 32'hF7FF_FFFF, 32'h07FF_FFFF};
    vout = '{16'h7FFF, 16'h8000, 16'h7FFF};
`ifdef ROUND_NEAREST_EN
    // Rounding lifts 0xF7FF_FFFF back onto the limit and pushes 0x07FF_FFFF over it.
    vfl  = '{2'b10, 2'b00, 2'b10};
`else
    vfl  = '{2'b10, 2'b01, 2'b00};
`endif
    for (int i = 0; i < 3; i++) begin
      in_data   = vin[i];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      n_checks++;
      if ({out_valid, out_data, out_ovf, out_unf} !== {1'b1, vout[i], vfl[i]}) begin
        $display("FAIL clip[%0d] got v=%b d=%h o=%b u=%b exp 1/%h/%b/%b",
                 i, out_valid, out_data, out_ovf, out_unf, vout[i], vfl[i][1], vfl[i][0]);
      end else n_pass++;
      step();
    end
  endtask

  task automatic test_round();
    logic [31:0] vin [3];
    logic [15:0] vout [3];
    logic [1:0]  vfl [3];
    vin  = '{32'h0000_0800, 32'hFFFF_F800, 32'h07FF_F800};
`ifdef ROUND_NEAREST_EN
    vout = '{16'h0001, 16'h0000, 16'h7FFF};
    vfl  = '{2'b00, 2'b00, 2'b10};
`else
    vout = '{16'h0000, 16'hFFFF, 16'h7FFF};
    vfl  = '{2'b00, 2'b00, 2'b00};
`endif
    for (int i = 0; i < 3; i++) begin
      in_data   = vin[i];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      n_checks++;
      if ({out_valid, out_data, out_ovf, out_unf} !== {1'b1, vout[i], vfl[i]}) begin
        $display("FAIL round[%0d] got v=%b d=%h o=%b u=%b exp 1/%h/%b/%b",
                 i, out_valid, out_data, out_ovf, out_unf, vout[i], vfl[i][1], vfl[i][0]);
      end else n_pass++;
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  pat;
    int          idx;
    int          oidx;
    int          occ;
    int          cyc;
    logic        in_hs;
    logic        out_hs;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        exp_in_ready;
    logic [15:0] exp_data;
    pat        = 4'b1001;  // out_ready per cycle: 1,0,0,1 repeating
    idx        = 0;
    oidx       = 0;
    occ        = 0;
    cyc        = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    while (oidx < 8 && cyc < 100) begin
      out_ready = pat[3 - (cyc % 4)];
      in_valid  = (idx < 8);
      in_data   = 32'(idx + 1) * 32'h0010_0000;
      #1;
      exp_in_ready = !(occ == 2 && !out_ready);
      n_checks++;
      if (in_ready !== exp_in_ready) begin
        $display("FAIL bp_in_ready cyc=%0d got %b exp %b", cyc, in_ready, exp_in_ready);
      end else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, prev_data}) begin
          $display("FAIL bp_stall_hold cyc=%0d got v=%b d=%h exp 1/%h",
                   cyc, out_valid, out_data, prev_data);
        end else n_pass++;
      end
      in_hs  = in_valid && in_ready;
      out_hs = out_valid && out_ready;
      if (out_hs) begin
        exp_data = 16'(oidx + 1) * 16'h0100;
        n_checks++;
        if ({out_data, out_ovf, out_unf} !== {exp_data, 2'b00}) begin
          $display("FAIL bp_data[%0d] got d=%h o=%b u=%b exp %h/0/0",
                   oidx, out_data, out_ovf, out_unf, exp_data);
        end else n_pass++;
        oidx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (in_hs) idx++;
      occ = occ + (in_hs ? 1 : 0) - (out_hs ? 1 : 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (oidx !== 8) begin
      $display("FAIL bp_count got %0d outputs exp 8", oidx);
    end else n_pass++;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_drain got out_valid=%b exp 0 (duplicate output)", out_valid);
    end else n_pass++;
  endtask

  task automatic test_counters();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    for (int i = 0; i < 3; i++) send_one(32'h0800_0000);
    for (int i = 0; i < 2; i++) send_one(32'hF000_0000);
    n_checks++;
    if ({ovf_count, unf_count} !== {16'd3, 16'd2}) begin
      $display("FAIL cnt_basic got ovf=%0d unf=%0d exp 3/2", ovf_count, unf_count);
    end else n_pass++;
    n_checks++;
    if ({s_ovf_count, s_unf_count} !== {2'd3, 2'd2}) begin
      $display("FAIL cnt_small got ovf=%0d unf=%0d exp 3/2", s_ovf_count, s_unf_count);
    end else n_pass++;
    for (int i = 0; i < 2; i++) send_one(32'h0800_0000);
    n_checks++;
    if (ovf_count !== 16'd5) begin
      $display("FAIL cnt_five got ovf=%0d exp 5", ovf_count);
    end else n_pass++;
    n_checks++;
    if (s_ovf_count !== 2'd3) begin
      $display("FAIL cnt_sat got ovf=%0d exp 3", s_ovf_count);
    end else n_pass++;
    // Clear on the same cycle as an ovf handshake.
    in_data   = 32'h0800_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_checks++;
    if ({out_valid, out_ovf} !== 2'b11) begin
      $display("FAIL cnt_pending got v=%b o=%b exp 1/1", out_valid, out_ovf);
    end else n_pass++;
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    n_checks++;
    if ({ovf_count, unf_count, s_ovf_count} !== {16'd0, 16'd0, 2'd0}) begin
      $display("FAIL cnt_clear_race got ovf=%0d unf=%0d small=%0d exp 0/0/0",
               ovf_count, unf_count, s_ovf_count);
    end else n_pass++;
    step();
    n_checks++;
    if (ovf_count !== 16'd0) begin
      $display("FAIL cnt_clear_hold got ovf=%0d exp 0", ovf_count);
    end else n_pass++;
  endtask

  task automatic test_reset_midstream();
    int stale;
    send_one(32'h0800_0000);
    n_checks++;
    if (ovf_count !== 16'd1) begin
      $display("FAIL mid_pre_cnt got ovf=%0d exp 1", ovf_count);
    end else n_pass++;
    out_ready = 1'b0;
    in_data   = 32'h0100_0000;
    in_valid  = 1'b1;
    step();
    in_data = 32'h0200_0000;
    step();
    in_valid = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 16'h1000}) begin
      $display("FAIL mid_full got in_ready=%b v=%b d=%h exp 0/1/1000",
               in_ready, out_valid, out_data);
    end else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({out_valid, ovf_count, unf_count, in_ready} !== {1'b0, 16'd0, 16'd0, 1'b1}) begin
      $display("FAIL mid_reset got v=%b ovf=%0d unf=%0d in_ready=%b exp 0/0/0/1",
               out_valid, ovf_count, unf_count, in_ready);
    end else n_pass++;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid === 1'b1) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      $display("FAIL mid_stale got %0d stale outputs exp 0", stale);
    end else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_clear = 1'b0;
    test_reset();
    test_nominal();
    test_clip();
    test_round();
    test_back_to_back();
    test_counters();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
